memwriter: RTL and testbench

Byte-stream memory loader: accepts framed write commands on an 8-bit valid/ready input, assembles DWIDTH-bit words and drives a single synchronous write port (address, data, write-enable) into a block RAM. It is the writer-side counterpart to our read-only memory ports. It is used to load code and data images from a serial or debug link into dual-port RAM while the other port is being read.

---
 rtl/memwriter_pkg.sv | 23 ++
 rtl/memwriter.sv | 147 ++++++++++++++
 tb/tb_memwriter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memwriter_pkg.sv
// memwriter_pkg: FSM state encoding and frame opcode shared by the memwriter slice.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

package memwriter_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ADR_HI = 3'd1,
      ADR_LO = 3'd2,
      CNT_HI = 3'd3,
      CNT_LO = 3'd4,
      DATA   = 3'd5,
      WRITE  = 3'd6,
      DONE   = 3'd7
   } state_t;

   localparam logic [7:0] OPC_WRITE = 8'h57;

endpackage

`default_nettype wire

// File: rtl/memwriter.sv
// memwriter: framed byte-stream loader that assembles big-endian words onto a RAM write port.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module memwriter
   import memwriter_pkg::*;
#(
   parameter int AWIDTH = 16,
   parameter int DWIDTH = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [AWIDTH-1:0] mem_adr,
   output logic [DWIDTH-1:0] mem_dat,
   output logic              mem_we,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int NBYTES = DWIDTH / 8;
   localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

   state_t              state;
   logic [BCW-1:0]      byte_cnt;
   logic [15:0]         adr;
   logic [15:0]         cnt;
   logic [DWIDTH-1:0]   shreg;
   logic                accept;
   logic [DWIDTH+7:0]   wide;
   logic [DWIDTH-1:0]   shifted;

   always_comb begin
      accept  = in_valid & in_ready;
      wide    = {shreg, in_data};
      shifted = wide[DWIDTH-1:0];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         byte_cnt <= '0;
         adr      <= '0;
         cnt      <= '0;
         shreg    <= '0;
         in_ready <= 1'b1;
         mem_adr  <= '0;
         mem_dat  <= '0;
         mem_we   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (in_data == OPC_WRITE) begin
                     state <= ADR_HI;
                     busy  <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            ADR_HI: begin
               if (accept) begin
                  adr[15:8] <= in_data;
                  state     <= ADR_LO;
               end
            end
            ADR_LO: begin
               if (accept) begin
                  adr[7:0] <= in_data;
                  state    <= CNT_HI;
               end
            end
            CNT_HI: begin
               if (accept) begin
                  cnt[15:8] <= in_data;
                  state     <= CNT_LO;
               end
            end
            CNT_LO: begin
               if (accept) begin
                  cnt[7:0] <= in_data;
                  byte_cnt <= '0;
                  if ({cnt[15:8], in_data} == 16'd0) begin
                     state    <= DONE;
                     in_ready <= 1'b0;
                     done     <= 1'b1;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (accept) begin
                  shreg <= shifted;
                  if (byte_cnt == LAST_BYTE) begin
                     // Launch the write straight from the completed word so it lands in WRITE.
                     state    <= WRITE;
                     in_ready <= 1'b0;
                     mem_we   <= 1'b1;
                     mem_adr  <= adr[AWIDTH-1:0];
                     mem_dat  <= shifted;
                     byte_cnt <= '0;
                  end else begin
                     byte_cnt <= byte_cnt + BCW'(1);
                  end
               end
            end
            WRITE: begin
               cnt <= cnt - 16'd1;
               adr <= adr + 16'd1;
               if (cnt == 16'd1) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state    <= DATA;
                  in_ready <= 1'b1;
               end
            end
            DONE: begin
               state    <= IDLE;
               busy     <= 1'b0;
               in_ready <= 1'b1;
            end
            default: begin
               state    <= IDLE;
               busy     <= 1'b0;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_memwriter.sv
// tb_memwriter: directed self-checking bench for the memwriter byte-stream loader.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_memwriter;

   logic        clk_i;
   logic        rst_i;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] mem_adr;
   logic [31:0] mem_dat;
   logic        mem_we;
   logic        busy;
   logic        done;
   logic        err;

   int checks;
   int errors;
   int ready_viol;
   logic [15:0] wadr[$];
   logic [31:0] wdat[$];
   logic [31:0] fw[0:3];

   memwriter #(.AWIDTH(16), .DWIDTH(32)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .in_data (in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .mem_adr (mem_adr),
      .mem_dat (mem_dat),
      .mem_we  (mem_we),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (!rst_i && mem_we) begin
         wadr.push_back(mem_adr);
         wdat.push_back(mem_dat);
         if (in_ready !== 1'b0) ready_viol++;
      end
   end

   // Returns #1 after the edge that accepted the byte.
   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 100) begin
         @(posedge clk_i); #1;
         n++;
      end
      if (n >= 100) begin
         $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
         $fatal(1, "in_ready stuck low");
      end
      @(posedge clk_i); #1;
      in_valid = 1'b0;
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(posedge clk_i); #1;
      end
   endtask

   task automatic send_frame(input logic [15:0] a, input logic [15:0] c, input int maxgap);
      send(8'h57); send(a[15:8]); send(a[7:0]); send(c[15:8]); send(c[7:0]);
      for (int w = 0; w < int'(c); w++) begin
         for (int k = 3; k >= 0; k--) begin
            if (maxgap > 0) gap($urandom_range(maxgap, 0));
            send(fw[w][k*8 +: 8]);
         end
      end
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 50) begin
         @(posedge clk_i); #1;
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s_done_timeout: done=%b required 1", name, done);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1; in_valid = 1'b0; in_data = 8'h00;
      repeat (2) @(posedge clk_i);
      #1;
      checks++;
      if ({in_ready, mem_we, busy, done, err} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_flags: {rdy,we,busy,done,err}=%b required 10000",
                  {in_ready, mem_we, busy, done, err});
      end
      checks++;
      if (mem_adr !== 16'h0 || mem_dat !== 32'h0) begin
         errors++;
         $display("FAIL reset_bus: adr=%h dat=%h required 0000 00000000", mem_adr, mem_dat);
      end
      @(negedge clk_i); rst_i = 1'b0;
      @(posedge clk_i); #1;
   endtask

   task automatic test_single();
      wadr.delete(); wdat.delete();
      send(8'h57); send(8'h00); send(8'h10); send(8'h00); send(8'h01);
      send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
      checks++;
      if (mem_we !== 1'b1 || mem_adr !== 16'h0010 || mem_dat !== 32'hDEADBEEF || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL single_write: we=%b adr=%h dat=%h rdy=%b required 1 0010 deadbeef 0",
                  mem_we, mem_adr, mem_dat, in_ready);
      end
      @(posedge clk_i); #1;
      checks++;
      if (done !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_done: done=%b we=%b busy=%b required 1 0 1", done, mem_we, busy);
      end
      @(posedge clk_i); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || wadr.size() != 1) begin
         errors++;
         $display("FAIL single_idle: done=%b busy=%b rdy=%b writes=%0d required 0 0 1 1",
                  done, busy, in_ready, wadr.size());
      end
   endtask

   task automatic test_wrap();
      wadr.delete(); wdat.delete();
      fw[0] = 32'h11223344; fw[1] = 32'h55667788;
      send_frame(16'hFFFF, 16'd2, 0);
      wait_done("wrap");
      @(posedge clk_i); #1;
      checks++;
      if (wadr.size() != 2) begin
         errors++;
         $display("FAIL wrap_count: writes=%0d required 2", wadr.size());
      end else begin
         checks++;
         if (wadr[0] !== 16'hFFFF || wdat[0] !== 32'h11223344 ||
             wadr[1] !== 16'h0000 || wdat[1] !== 32'h55667788) begin
            errors++;
            $display("FAIL wrap_data: %h/%h %h/%h required ffff/11223344 0000/55667788",
                     wadr[0], wdat[0], wadr[1], wdat[1]);
         end
      end
      checks++;
      if (mem_we !== 1'b0 || mem_adr !== 16'h0000 || mem_dat !== 32'h55667788) begin
         errors++;
         $display("FAIL wrap_hold: we=%b adr=%h dat=%h required 0 0000 55667788",
                  mem_we, mem_adr, mem_dat);
      end
   endtask

   task automatic test_bad_opcode();
      wadr.delete(); wdat.delete();
      send(8'h41);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || mem_we !== 1'b0) begin
         errors++;
         $display("FAIL err_pulse: err=%b busy=%b we=%b required 1 0 0", err, busy, mem_we);
      end
      @(posedge clk_i); #1;
      checks++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL err_clear: err=%b busy=%b required 0 0", err, busy);
      end
      fw[0] = 32'hCAFEBABE;
      send_frame(16'h0100, 16'd1, 0);
      wait_done("err_recover");
      @(posedge clk_i); #1;
      checks++;
      if (wadr.size() != 1 || wadr[0] !== 16'h0100 || wdat[0] !== 32'hCAFEBABE) begin
         errors++;
         $display("FAIL err_recover: writes=%0d first=%h/%h required 1 0100/cafebabe",
                  wadr.size(), wadr.size() > 0 ? wadr[0] : 16'hx, wdat.size() > 0 ? wdat[0] : 32'hx);
      end
   endtask

   task automatic test_zero_count();
      wadr.delete(); wdat.delete();
      send(8'h57); send(8'h12); send(8'h34); send(8'h00); send(8'h00);
      checks++;
      if (done !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL zero_done: done=%b we=%b busy=%b rdy=%b required 1 0 1 0",
                  done, mem_we, busy, in_ready);
      end
      @(posedge clk_i); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || wadr.size() != 0) begin
         errors++;
         $display("FAIL zero_after: done=%b busy=%b writes=%0d required 0 0 0",
                  done, busy, wadr.size());
      end
   endtask

   task automatic test_gaps();
      wadr.delete(); wdat.delete();
      ready_viol = 0;
      fw[0] = 32'hA1B2C3D4; fw[1] = 32'h01234567; fw[2] = 32'h89ABCDEF;
      send_frame(16'h2000, 16'd3, 3);
      wait_done("gaps");
      @(posedge clk_i); #1;
      checks++;
      if (wadr.size() != 3 || ready_viol != 0) begin
         errors++;
         $display("FAIL gaps_count: writes=%0d ready_viol=%0d required 3 0", wadr.size(), ready_viol);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (wadr[i] !== 16'h2000 + 16'(i) || wdat[i] !== fw[i]) begin
               errors++;
               $display("FAIL gaps_word%0d: %h/%h required %h/%h",
                        i, wadr[i], wdat[i], 16'h2000 + 16'(i), fw[i]);
            end
         end
      end
   endtask

   task automatic test_reset_midframe();
      wadr.delete(); wdat.delete();
      send(8'h57); send(8'h30); send(8'h00); send(8'h00); send(8'h01);
      send(8'hAA); send(8'hBB);
      #2 rst_i = 1'b1;
      #1;
      checks++;
      if ({in_ready, mem_we, busy, done, err} !== 5'b10000 || mem_adr !== 16'h0 || mem_dat !== 32'h0) begin
         errors++;
         $display("FAIL midreset_async: {rdy,we,busy,done,err}=%b adr=%h dat=%h required 10000 0000 00000000",
                  {in_ready, mem_we, busy, done, err}, mem_adr, mem_dat);
      end
      @(negedge clk_i); rst_i = 1'b0;
      fw[0] = 32'h01020304;
      send_frame(16'h3000, 16'd1, 0);
      wait_done("midreset");
      @(posedge clk_i); #1;
      checks++;
      if (wadr.size() != 1 || wadr[0] !== 16'h3000 || wdat[0] !== 32'h01020304) begin
         errors++;
         $display("FAIL midreset_frame: writes=%0d first=%h/%h required 1 3000/01020304",
                  wadr.size(), wadr.size() > 0 ? wadr[0] : 16'hx, wdat.size() > 0 ? wdat[0] : 32'hx);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      ready_viol = 0;
      test_reset();
      test_single();
      test_wrap();
      test_bad_opcode();
      test_zero_count();
      test_gaps();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
